// File: rtl/row_seq_pkg.sv
// row_seq_pkg: shared game constants and the per-row difficulty rule for the row sequencer.
package row_seq_pkg;
    localparam logic GO_LEFT  = 1'b0;
    localparam logic GO_RIGHT = 1'b1;
    localparam int MIN_DIFF = 1;
    localparam int LEVEL_W  = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    // Higher rows and higher levels move faster, but never below one frame per pixel.
    function automatic logic [2:0] calc_diff(input int low, input int row, input int lvl);
        int d;
        d = low - ((row + 1) >>> 1) - lvl;
        return 3'(d < MIN_DIFF ? MIN_DIFF : d);
    endfunction
endpackage

// File: rtl/frame_pacer.sv
// frame_pacer: counts frame ticks and emits a one-cycle move pulse every 'period' ticks.
module frame_pacer
    import row_seq_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic [2:0] period,
    output logic       move_pulse
);
    logic [2:0] count;
    logic       hit;

    assign hit = frame_tick && count == period - 3'd1;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            count      <= '0;
            move_pulse <= 1'b0;
        end else begin
            move_pulse <= hit;
            if (frame_tick)
                count <= hit ? '0 : count + 3'd1;
        end
    end
endmodule

// File: rtl/row_sequencer.sv
// row_sequencer: steps through tower rows, publishing spawn position, direction and pace per row.
// Define ROW_SEQ_WRAP_EN to wrap to row 0 and raise the level instead of finishing the tower.
module row_sequencer
    import row_seq_pkg::*;
#(
    parameter int NUM_ROWS = 7,
    parameter int ROW_H    = 16,
    parameter int Y_BASE   = 104,
    parameter int X_INIT   = 0,
    parameter int X_END    = 144,
    parameter int LOW_DIFF = 4
)(
    input  logic               clk,
    input  logic               resetn,
    input  logic               inc_row,
    input  logic               frame_tick,
    output logic [4:0]         row_idx,
    output logic [6:0]         new_y_position,
    output logic [7:0]         new_x_position,
    output logic               new_direction,
    output logic [2:0]         difficulty,
    output logic               move_pulse,
    output logic               row_load,
    output logic               tower_done,
    output logic [LEVEL_W-1:0] level
);
    logic               accept, last, rst_d, nxt_done;
    logic [4:0]         nxt_row;
    logic [LEVEL_W-1:0] nxt_lvl;

    always_comb begin
        accept = inc_row && !tower_done;
        last   = row_idx == 5'(NUM_ROWS - 1);
`ifdef ROW_SEQ_WRAP_EN
        nxt_row  = accept ? (last ? '0 : row_idx + 5'd1) : row_idx;
        nxt_lvl  = accept && last && level != LEVEL_MAX ? LEVEL_W'(level + 1) : level;
        nxt_done = 1'b0;
`else
        nxt_row  = accept && !last ? row_idx + 5'd1 : row_idx;
        nxt_lvl  = '0;
        nxt_done = tower_done || (accept && last);
`endif
    end

    // Row-derived outputs are computed from the next row so they land with the row change.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_idx        <= '0;
            new_y_position <= 7'(Y_BASE);
            new_x_position <= 8'(X_INIT);
            new_direction  <= GO_RIGHT;
            difficulty     <= 3'(LOW_DIFF);
            level          <= '0;
            tower_done     <= 1'b0;
            row_load       <= 1'b0;
            rst_d          <= 1'b1;
        end else begin
            row_idx        <= nxt_row;
            new_y_position <= 7'(Y_BASE - int'(nxt_row) * ROW_H);
            new_x_position <= nxt_row[0] ? 8'(X_END) : 8'(X_INIT);
            new_direction  <= nxt_row[0] ? GO_LEFT : GO_RIGHT;
            difficulty     <= calc_diff(LOW_DIFF, int'(nxt_row), int'(nxt_lvl));
            level          <= nxt_lvl;
            tower_done     <= nxt_done;
            row_load       <= accept || rst_d;
            rst_d          <= 1'b0;
        end
    end

    frame_pacer u_pacer (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (accept),
        .frame_tick (frame_tick && !tower_done),
        .period     (difficulty),
        .move_pulse (move_pulse)
    );
endmodule

// File: tb/tb_row_sequencer.sv
// tb_row_sequencer: directed scenarios plus random stimulus checked against a behavioural model.
module tb_row_sequencer;
    localparam int N  = 7;
    localparam int RH = 16;
    localparam int YB = 104;
    localparam int XI = 0;
    localparam int XE = 144;
    localparam int LD = 4;

    logic       clk = 1'b0, resetn = 1'b0, inc_row = 1'b0, frame_tick = 1'b0;
    logic [4:0] row_idx;
    logic [6:0] new_y_position;
    logic [7:0] new_x_position;
    logic       new_direction, move_pulse, row_load, tower_done;
    logic [2:0] difficulty;
    logic [3:0] level;

    int checks = 0, failures = 0;
    int m_row = 0, m_lvl = 0, m_cnt = 0;
    bit m_done = 0, m_mp = 0, m_rl = 0, m_rst = 0;

    always #5 clk = ~clk;

    row_sequencer #(
        .NUM_ROWS(N), .ROW_H(RH), .Y_BASE(YB), .X_INIT(XI), .X_END(XE), .LOW_DIFF(LD)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inc_row        (inc_row),
        .frame_tick     (frame_tick),
        .row_idx        (row_idx),
        .new_y_position (new_y_position),
        .new_x_position (new_x_position),
        .new_direction  (new_direction),
        .difficulty     (difficulty),
        .move_pulse     (move_pulse),
        .row_load       (row_load),
        .tower_done     (tower_done),
        .level          (level)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_diff(input int r, input int l);
        int d;
        d = LD - (r + 1) / 2 - l;
        return d < 1 ? 1 : d;
    endfunction

    task automatic model_step(input bit rn, input bit i, input bit t);
        if (!rn) begin
            m_row = 0; m_lvl = 0; m_done = 0; m_cnt = 0; m_mp = 0; m_rl = 0; m_rst = 1;
        end else begin
            m_rl = m_rst; m_rst = 0; m_mp = 0;
            if (i && !m_done) begin
                m_cnt = 0; m_rl = 1;
                if (m_row == N - 1) begin
`ifdef ROW_SEQ_WRAP_EN
                    m_row = 0;
                    if (m_lvl < 15) m_lvl++;
`else
                    m_done = 1;
`endif
                end else m_row++;
            end else if (t && !m_done) begin
                if (m_cnt == exp_diff(m_row, m_lvl) - 1) begin
                    m_mp = 1; m_cnt = 0;
                end else m_cnt++;
            end
        end
    endtask

    task automatic check_all(input string p);
        check({p, "_row"},   row_idx, m_row);
        check({p, "_y"},     new_y_position, (YB - m_row * RH) & 127);
        check({p, "_x"},     new_x_position, m_row % 2 ? XE : XI);
        check({p, "_dir"},   new_direction, m_row % 2 ? 0 : 1);
        check({p, "_diff"},  difficulty, exp_diff(m_row, m_lvl));
        check({p, "_mp"},    move_pulse, m_mp);
        check({p, "_load"},  row_load, m_rl);
        check({p, "_done"},  tower_done, m_done);
        check({p, "_level"}, level, m_lvl);
    endtask

    task automatic cycle(input string p, input bit rn, input bit i, input bit t);
        resetn = rn; inc_row = i; frame_tick = t;
        @(posedge clk);
        model_step(rn, i, t);
        #1;
        inc_row = 1'b0; frame_tick = 1'b0;
        check_all(p);
    endtask

    initial begin
        cycle("rst", 0, 0, 0);
        cycle("rst", 0, 1, 1);
        check("rst_y_const", new_y_position, 104);
        check("rst_diff_const", difficulty, 4);
        check("rst_load_const", row_load, 0);
        cycle("rel", 1, 0, 0);
        check("rel_load_const", row_load, 1);

        for (int k = 0; k < 3; k++) begin
            cycle("s36", 1, 0, 1);
            check("s36_no_pulse", move_pulse, 0);
        end
        cycle("s36", 1, 0, 1);
        check("s36_pulse", move_pulse, 1);
        check("s36_y", new_y_position, 104);
        check("s36_x", new_x_position, 0);
        check("s36_dir", new_direction, 1);

        for (int k = 0; k < 3; k++) cycle("s38pre", 1, 0, 1);
        cycle("s38", 1, 1, 1);
        check("s38_no_pulse", move_pulse, 0);
        check("s37_row", row_idx, 1);
        check("s37_y", new_y_position, 88);
        check("s37_x", new_x_position, 144);
        check("s37_dir", new_direction, 0);
        check("s37_diff", difficulty, 3);
        check("s37_load", row_load, 1);
        for (int k = 0; k < 2; k++) begin
            cycle("s38", 1, 0, 1);
            check("s38_wait", move_pulse, 0);
        end
        cycle("s38", 1, 0, 1);
        check("s38_pulse", move_pulse, 1);

        for (int k = 0; k < 6; k++) cycle("s39", 1, 1, 0);
`ifdef ROW_SEQ_WRAP_EN
        check("s40_row", row_idx, 0);
        check("s40_level", level, 1);
        check("s40_diff", difficulty, 3);
        check("s40_y", new_y_position, 104);
        check("s40_done", tower_done, 0);
`else
        check("s39_done", tower_done, 1);
        check("s39_row", row_idx, 6);
        cycle("s39", 1, 1, 1);
        check("s39_hold_row", row_idx, 6);
        for (int k = 0; k < 4; k++) begin
            cycle("s39", 1, 0, 1);
            check("s39_no_pulse", move_pulse, 0);
        end
`endif

        cycle("s41", 0, 0, 0);
        cycle("s41", 1, 0, 0);
        for (int k = 0; k < 4; k++) cycle("s41", 1, 1, 0);
        check("s41_at4", row_idx, 4);
        cycle("s41", 0, 1, 1);
        check("s41_row", row_idx, 0);
        check("s41_y", new_y_position, 104);
        check("s41_dir", new_direction, 1);
        check("s41_load_low", row_load, 0);
        cycle("s41", 1, 0, 0);
        check("s41_load", row_load, 1);

        for (int k = 0; k < 800; k++)
            cycle("rnd", $urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
